// File: rtl/spi_cfg_pkg.sv
// Shared types for the configurable SPI master: FSM states, latched SPI mode,
// and the sizing helper for the SCK edge counter.
package spi_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_XFER,
    ST_TRAIL,
    ST_DONE
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Edge counter must hold 0 .. 2*data_w without wrapping.
  function automatic int edge_cnt_w(input int data_w);
    return $clog2(2 * data_w + 1);
  endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// Half-period timer: one-cycle tick every CLK_DIV cycles while en is high.
// Down-counter with terminal-count compare; reloaded whenever en is low.
module spi_clk_tick
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == '0);

  // Holding the reload value while disabled means every enable rise starts a full period.
  always_comb begin
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = RELOAD;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_cfg.sv
// Full-duplex SPI master with configurable width, divider, CPOL/CPHA and chip selects.
// Optional LSB-first ordering when SPI_MASTER_CFG_LSB_FIRST_EN is defined.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; sck at last latched cpol, mosi held
// ST_LEAD  | cs_n asserted, CLK_DIV cycles before the first sck edge
// ST_XFER  | 2*DATA_W sck edges, one every CLK_DIV cycles
// ST_TRAIL | sck back at cpol, cs_n still asserted for CLK_DIV cycles
// ST_DONE  | one cycle: done pulse, rx_data valid, cs_n released
module spi_master_cfg
  import spi_cfg_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int CLK_DIV = 2,
  parameter  int NUM_CS  = 2,
  localparam int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
`ifdef SPI_MASTER_CFG_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic              miso,
  output logic              mosi,
  output logic              sck,
  output logic [NUM_CS-1:0] cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int EC_W = edge_cnt_w(DATA_W);
  localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_W - 1);

  spi_state_e        state_q, state_d;
  spi_mode_t         mode_q, mode_d;
  logic              lsb_q, lsb_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [EC_W-1:0]   edge_q, edge_d;
  logic              mosi_q, mosi_d;
  logic              sck_q, sck_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              tick;
  logic              lsb_in;
  logic [DATA_W-1:0] data_rev, rx_rev, tx_src;
  logic [NUM_CS-1:0] cs_dec;
  logic              sample_edge, drive_edge;

`ifdef SPI_MASTER_CFG_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (busy_q),
    .tick (tick)
  );

  // LSB-first is handled by reversing the word at the edges of the shifter.
  always_comb begin
    data_rev = '0;
    rx_rev   = '0;
    for (int i = 0; i < DATA_W; i++) begin
      data_rev[i] = data_in[DATA_W-1-i];
      rx_rev[i]   = rx_sh_q[DATA_W-1-i];
    end
    tx_src = lsb_in ? data_rev : data_in;
  end

  // Out-of-range cs_sel matches no line, so the transfer runs with every cs_n high.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (CS_W'(i) == cs_sel) cs_dec[i] = 1'b0;
    end
  end

  // edge_q[0]==0 means the next edge is a leading one.
  assign sample_edge = (edge_q[0] == mode_q.cpha);
  assign drive_edge  = !sample_edge && (mode_q.cpha || (edge_q != LAST_EDGE));

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    lsb_d     = lsb_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    edge_d    = edge_q;
    mosi_d    = mosi_q;
    sck_d     = sck_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d     = ST_LEAD;
          mode_d.cpol = cpol;
          mode_d.cpha = cpha;
          lsb_d       = lsb_in;
          busy_d      = 1'b1;
          cs_n_d      = cs_dec;
          sck_d       = cpol;
          edge_d      = '0;
          rx_sh_d     = '0;
          if (!cpha) begin
            mosi_d = tx_src[DATA_W-1];
            tx_d   = {tx_src[DATA_W-2:0], 1'b0};
          end else begin
            tx_d = tx_src;
          end
        end
      end
      ST_LEAD: begin
        if (tick) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (tick) begin
          sck_d  = ~sck_q;
          edge_d = edge_q + EC_W'(1);
          if (sample_edge) rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
          if (drive_edge) begin
            mosi_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
          if (edge_q == LAST_EDGE) state_d = ST_TRAIL;
        end
      end
      ST_TRAIL: begin
        if (tick) begin
          state_d   = ST_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          cs_n_d    = '1;
          sck_d     = mode_q.cpol;
          rx_data_d = lsb_q ? rx_rev : rx_sh_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= '0;
      lsb_q     <= 1'b0;
      tx_q      <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      edge_q    <= '0;
      mosi_q    <= 1'b0;
      sck_q     <= 1'b0;
      cs_n_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      lsb_q     <= lsb_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      edge_q    <= edge_d;
      mosi_q    <= mosi_d;
      sck_q     <= sck_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign mosi    = mosi_q;
  assign sck     = sck_q;
  assign cs_n    = cs_n_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule

// File: doc/spi_master_cfg.md
Name: spi_master_cfg

Overview:
- Parametrised successor to the fixed 8-bit, mode-0, single-CS SPI master.
- Full-duplex SPI master with configurable word width, SCK divider, runtime CPOL/CPHA selection, multiple chip selects, and captured MISO data.
- Sits between a register/command front-end that pulses start and downstream SPI peripherals.

Parameters:
- DATA_W, 8, bits per transfer (>=2).
- CLK_DIV, 2, clk cycles per SCK half-period (>=1); also the CS lead time and CS trail time.
- NUM_CS, 2, number of chip-select lines (>=1).
- CS_W, $clog2(NUM_CS) min 1, width of cs_sel (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle request; ignored while busy.
- data_in  in  DATA_W  TX word, latched on accepted start.
- cs_sel  in  CS_W  target chip select, latched on start.
- cpol  in  1  SCK idle level, latched on start.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge. Latched on start.
- miso  in  1  serial data from slave.
- mosi  out  1  serial data to slave, MSB first.
- sck  out  1  SPI clock.
- cs_n  out  NUM_CS  active-low chip selects.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at transfer end.
- rx_data  out  DATA_W  received word; valid from done, held until next done.

Behaviour:
- Reset values: mosi=0, sck=0, cs_n=all 1, busy=0, done=0, rx_data=0. Latched cpol=0. FSM enters IDLE.
- Reset mid-transfer aborts immediately (asynchronous). No done pulse is produced.
- FSM: IDLE -> LEAD -> XFER -> TRAIL -> DONE -> IDLE.
- IDLE: on start=1 at edge N:
  - latch data_in, cs_sel, cpol, cpha;
  - after edge N: busy=1 and cs_n[cs_sel]=0;
  - enter LEAD.
- LEAD: lasts CLK_DIV cycles with sck=cpol.
  - If cpha=0, mosi = data MSB from edge N.
- XFER: 2*DATA_W half-periods of CLK_DIV cycles each. sck toggles at the end of every half-period.
  - cpha=0: sample miso on odd (leading) edges; shift mosi on even (trailing) edges, except after the last edge.
  - cpha=1: drive next bit on leading edges (the first leading edge drives the MSB); sample on trailing edges.
- TRAIL: CLK_DIV cycles. sck is back at cpol; cs_n is still asserted.
- DONE: one cycle.
  - done=1, busy=0, cs_n=all 1;
  - rx_data updated with the captured word (MSB received first).
- Latency: busy is high for exactly (2*DATA_W+2)*CLK_DIV cycles. done is asserted in the following cycle.
- A start during the DONE cycle is accepted (busy=0). cs_n is then high for exactly that one cycle.
- A start while busy=1 is ignored and not queued.
- cs_sel >= NUM_CS: the transfer runs normally, no cs_n line asserts, and done still pulses.
- sck idles at the most recently latched cpol. mosi holds its last value when idle.
- Divider counter and bit counter are sized for CLK_DIV and 2*DATA_W without overflow.

Optional Feature:
- Macro: SPI_MASTER_CFG_LSB_FIRST_EN.
- When defined: adds input port lsb_first (1 bit), latched on start.
  - When latched as 1, TX shifts out LSB first and RX assembles LSB first.
- When undefined: port is absent and ordering is always MSB first.
- Timing is identical in both builds.

Decomposition:
- Package spi_cfg_pkg holds:
  - state enum typedef (IDLE, LEAD, XFER, TRAIL, DONE);
  - SPI mode typedef {cpol, cpha};
  - localparam helper for the bit-counter width.
- Sub-module spi_clk_tick: counter that emits a one-cycle tick every CLK_DIV cycles while enabled; it is cleared on enable rise.
- The FSM and shift registers stay in spi_master_cfg.

Test Plan (a slave model returns a fixed word on miso per mode):
- DATA_W=8, CLK_DIV=2, mode 0 (cpol=0, cpha=0), data_in=0xA5, slave returns 0x3C, cs_sel=0:
  - mosi = 1,0,1,0,0,1,0,1 on rising edges;
  - rx_data=0x3C;
  - busy high 36 cycles;
  - only cs_n[0] low.
- Mode 3 (cpol=1, cpha=1), data_in=0x3C, slave returns 0xC3, cs_sel=1:
  - sck idles high;
  - data sampled on rising edges;
  - rx_data=0xC3;
  - cs_n=2'b01 during the transfer.
- Back-to-back: start in the DONE cycle with 0x11 then 0x22:
  - cs_n high exactly 1 cycle between transfers;
  - two done pulses;
  - rx_data updates each time.
- start pulsed at cycle 10 of an active transfer: ignored; done count = 1; data unchanged.
- rst asserted mid-XFER (bit 4):
  - all outputs return to reset values asynchronously;
  - no done pulse;
  - next transfer of 0x5A completes correctly.
- CLK_DIV=1, DATA_W=16, data_in=0xBEEF, mode 1: busy high 34 cycles; rx_data matches the slave word 0x1234.
